// File: rtl/mic_level_meter.sv
// Microphone peak level meter: windowed peak detection driving a thermometer LED bar.
// Optional peak-hold marker is built when MIC_LEVEL_METER_PEAK_HOLD_EN is defined.
module mic_level_meter #(
  parameter int WIDTH    = 12,
  parameter int NLED     = 16,
  parameter int LVLW     = 5,
  parameter int WINDOW   = 2000,
  parameter int HOLD_WIN = 8
) (
  input  logic             CLOCK,
  input  logic             RESETN,
  input  logic             E,
  input  logic             sample_tick,
  input  logic [WIDTH-1:0] mic_in,
  input  logic [1:0]       mode,
  output logic [NLED-1:0]  led,
  output logic [LVLW-1:0]  level
);

  localparam int LB = $clog2(NLED);
  localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  // Top log2(NLED) bits of the peak select the bar; any non-zero peak lights at least one LED.
  function automatic logic [LVLW-1:0] level_of(input logic [WIDTH-1:0] pk);
    logic [WIDTH-1:0] top;
    top = pk >> (WIDTH - LB);
    if (pk == '0) begin
      level_of = '0;
    end else begin
      level_of = LVLW'(top) + LVLW'(1);
    end
  endfunction

  function automatic logic [NLED-1:0] bar_of(input logic [LVLW-1:0] lv);
    for (int i = 0; i < NLED; i++) begin
      bar_of[i] = (i < int'(lv));
    end
  endfunction

  logic             run_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] acc_r;
  logic [NLED-1:0]  led_r, led_s;
  logic [LVLW-1:0]  level_r, level_s;
  logic             go_s, tick_s, close_s;
  logic [WIDTH-1:0] peak_new_s;
  logic [LVLW-1:0]  lvl_new_s;
  logic [NLED-1:0]  marker_s;

  // One-stage release: the edge after RESETN rises arms the block, the next one is functional.
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
    end
  end

  assign go_s       = E && run_r;
  assign tick_s     = go_s && sample_tick;
  assign close_s    = tick_s && (count_r == CW'(WINDOW - 1));
  assign peak_new_s = (mic_in > acc_r) ? mic_in : acc_r;
  assign lvl_new_s  = level_of(peak_new_s);

  // The peak is only ever observed through its level encoding, so only the level is stored.
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      count_r <= '0;
      acc_r   <= '0;
    end else if (!go_s) begin
      count_r <= '0;
      acc_r   <= '0;
    end else if (close_s) begin
      count_r <= '0;
      acc_r   <= '0;
    end else if (tick_s) begin
      count_r <= count_r + CW'(1);
      acc_r   <= peak_new_s;
    end
  end

`ifdef MIC_LEVEL_METER_PEAK_HOLD_EN
  localparam int HW = $clog2(HOLD_WIN + 1);

  typedef enum logic {
    HOLD  = 1'b0,
    DECAY = 1'b1
  } hstate_t;

  hstate_t         state_r, state_s;
  logic [LVLW-1:0] hold_r, hold_s;
  logic [HW-1:0]   hcnt_r, hcnt_s;

  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      state_r <= HOLD;
      hold_r  <= '0;
      hcnt_r  <= '0;
    end else if (!go_s) begin
      state_r <= HOLD;
      hold_r  <= '0;
      hcnt_r  <= '0;
    end else begin
      state_r <= state_s;
      hold_r  <= hold_s;
      hcnt_r  <= hcnt_s;
    end
  end

  // Marker follows any level at or above it; otherwise it waits HOLD_WIN windows, then sinks one per window.
  always_comb begin
    state_s = state_r;
    hold_s  = hold_r;
    hcnt_s  = hcnt_r;
    if (close_s) begin
      if (lvl_new_s >= hold_r) begin
        hold_s  = lvl_new_s;
        hcnt_s  = HW'(HOLD_WIN);
        state_s = HOLD;
      end else begin
        case (state_r)
          HOLD: begin
            if (hcnt_r <= HW'(1)) begin
              hcnt_s  = '0;
              state_s = DECAY;
            end else begin
              hcnt_s = hcnt_r - HW'(1);
            end
          end
          DECAY: begin
            if (hold_r != '0) begin
              hold_s = hold_r - LVLW'(1);
            end else begin
              hold_s = hold_r;
            end
          end
          default: begin
            state_s = HOLD;
          end
        endcase
      end
    end else begin
      state_s = state_r;
    end
  end

  always_comb begin
    marker_s = '0;
    if (hold_s != '0) begin
      marker_s = NLED'(1) << (hold_s - LVLW'(1));
    end else begin
      marker_s = '0;
    end
  end
`else
  assign marker_s = '0;
`endif

  always_comb begin
    led_s   = led_r;
    level_s = level_r;
    if (!go_s) begin
      led_s   = '0;
      level_s = '0;
    end else begin
      if (close_s) begin
        level_s = lvl_new_s;
      end else begin
        level_s = level_r;
      end
      case (mode)
        2'd0: begin
          if (tick_s) begin
            led_s = NLED'(mic_in);
          end else begin
            led_s = led_r;
          end
        end
        2'd2: begin
          if (close_s) begin
            led_s = bar_of(lvl_new_s) | marker_s;
          end else begin
            led_s = led_r;
          end
        end
        default: begin
          if (close_s) begin
            led_s = bar_of(lvl_new_s);
          end else begin
            led_s = led_r;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      led_r   <= '0;
      level_r <= '0;
    end else begin
      led_r   <= led_s;
      level_r <= level_s;
    end
  end

  assign led   = led_r;
  assign level = level_r;

endmodule

// File: tb/tb_mic_level_meter.sv
// Scoreboarded bench for mic_level_meter: a window-list reference model predicts every cycle,
// a negedge monitor compares; directed scenarios add fixed expected values.
module tb_mic_level_meter;
  localparam int WIDTH    = 12;
  localparam int NLED     = 16;
  localparam int LVLW     = 5;
  localparam int WINDOW   = 4;
  localparam int HOLD_WIN = 2;
`ifdef MIC_LEVEL_METER_PEAK_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic             CLOCK = 1'b0;
  logic             RESETN = 1'b1;
  logic             E = 1'b0;
  logic             sample_tick = 1'b0;
  logic [WIDTH-1:0] mic_in = '0;
  logic [1:0]       mode = 2'd0;
  logic [NLED-1:0]  led;
  logic [LVLW-1:0]  level;

  mic_level_meter #(.WIDTH(WIDTH), .NLED(NLED), .LVLW(LVLW), .WINDOW(WINDOW), .HOLD_WIN(HOLD_WIN)) dut (
    .CLOCK(CLOCK), .RESETN(RESETN), .E(E), .sample_tick(sample_tick),
    .mic_in(mic_in), .mode(mode), .led(led), .level(level)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [NLED-1:0] led;
    logic [LVLW-1:0] level;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  int win[$];
  int m_led = 0, m_level = 0, m_hold = 0, m_age = 0;
  bit m_armed = 1'b0;

  function void model_clear();
    win.delete();
    m_led = 0; m_level = 0; m_hold = 0; m_age = 0;
  endfunction

  function void model_step(input bit r, input bit e, input bit t, input int mic, input int md);
    int pk;
    pk = 0;
    if (!r) begin
      model_clear();
      m_armed = 1'b0;
    end else if (!m_armed) begin
      m_armed = 1'b1;
    end else if (!e) begin
      model_clear();
    end else if (t) begin
      win.push_back(mic);
      if (md == 0) m_led = mic % (1 << NLED);
      if (win.size() == WINDOW) begin
        foreach (win[i]) if (win[i] > pk) pk = win[i];
        win.delete();
        m_level = (pk == 0) ? 0 : (pk * NLED) / (1 << WIDTH) + 1;
        if (m_level >= m_hold) begin
          m_hold = m_level;
          m_age  = 0;
        end else begin
          m_age++;
          if (m_age > HOLD_WIN && m_hold > 0) m_hold--;
        end
        if (md == 2 && HOLD_EN)
          m_led = ((1 << m_level) - 1) | ((m_hold > 0) ? (1 << (m_hold - 1)) : 0);
        else if (md != 0)
          m_led = (1 << m_level) - 1;
      end
    end
  endfunction

  task automatic check(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge CLOCK) begin
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      checks++;
      if (led !== x.led || level !== x.level) begin
        errors++;
        $display("FAIL scoreboard at %0t: led=0x%0h level=%0d expected led=0x%0h level=%0d",
                 $time, led, level, x.led, x.level);
      end
    end
  end

  task automatic cycle(input bit r, input bit e, input bit t, input int mic, input int md);
    exp_t x;
    @(negedge CLOCK);
    #1;
    RESETN = r; E = e; sample_tick = t; mic_in = WIDTH'(mic); mode = 2'(md);
    if (!r) begin
      #1;
      check("async_reset_led", int'(led), 0);
      check("async_reset_level", int'(level), 0);
    end
    @(posedge CLOCK);
    model_step(r, e, t, mic, md);
    x.led = NLED'(m_led);
    x.level = LVLW'(m_level);
    exp_q.push_back(x);
    #1;
  endtask

  initial begin
    int expv;
    int md;
    int mic;
    #1 RESETN = 1'b0;
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(1, 1, 1, 4095, 1);  // tick on the arming edge must be dropped
    cycle(1, 1, 0, 0, 1);
    check("post_reset_level", int'(level), 0);

    cycle(1, 1, 1, 100, 1);
    cycle(1, 1, 1, 3000, 1);
    cycle(1, 1, 1, 50, 1);
    check("mid_window_level", int'(level), 0);
    cycle(1, 1, 1, 7, 1);
    check("window_level", int'(level), 12);
    check("window_led", int'(led), 16'h0FFF);

    cycle(1, 1, 1, 12'hABC, 0);
    check("raw_led", int'(led), 16'h0ABC);
    cycle(1, 0, 0, 0, 0);
    check("disable_led", int'(led), 0);
    check("disable_level", int'(level), 0);

    cycle(1, 1, 0, 0, 2);
    for (int k = 0; k < WINDOW; k++) cycle(1, 1, 1, 4095, 2);
    check("full_scale_led", int'(led), 16'hFFFF);
    check("full_scale_level", int'(level), 16);
    for (int w = 1; w <= 18; w++) begin
      for (int k = 0; k < WINDOW; k++) cycle(1, 1, 1, 0, 2);
      if (HOLD_EN) expv = (w <= 2) ? 16'h8000 : ((w < 18) ? (1 << (17 - w)) : 0);
      else expv = 0;
      check("hold_marker", int'(led), expv);
    end
    check("silent_level", int'(level), 0);

    cycle(1, 1, 1, 4000, 1);
    cycle(1, 1, 1, 4000, 1);
    cycle(0, 1, 0, 0, 1);
    cycle(1, 1, 0, 0, 1);
    cycle(1, 1, 0, 0, 1);
    for (int k = 0; k < WINDOW; k++) cycle(1, 1, 1, 16, 1);
    check("partial_discard_level", int'(level), 1);
    check("partial_discard_led", int'(led), 16'h0001);

    for (int k = 0; k < 3; k++) cycle(1, 0, 1, 4095, 1);
    for (int k = 0; k < WINDOW - 1; k++) cycle(1, 1, 1, 512, 1);
    check("enable_early_level", int'(level), 0);
    cycle(1, 1, 1, 512, 1);
    check("enable_window_level", int'(level), 3);
    check("enable_window_led", int'(led), 16'h0007);

    for (int n = 0; n < 1500; n++) begin
      case ($urandom % 4)
        0: mic = 0;
        1: mic = int'($urandom % 16);
        2: mic = int'($urandom % 4096);
        default: mic = 4095;
      endcase
      md = int'($urandom % 4);
      cycle(($urandom % 200) != 0, ($urandom % 16) != 0, ($urandom % 3) == 0, mic, md);
    end

    cycle(1, 1, 0, 0, 1);
    for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(posedge CLOCK);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mic_level_meter.md
MIC_LEVEL_METER -- requirements
Module: mic_level_meter

Interface
REQ-001 Parameter: WIDTH, 12, mic sample width in bits.
REQ-002 Parameter: NLED, 16, LED count; power of two, at most 2^WIDTH.
REQ-003 Parameter: LVLW, 5, level width; SHALL satisfy 2^LVLW > NLED.
REQ-004 Parameter: WINDOW, 2000, sample ticks per peak window; at least 1.
REQ-005 Parameter: HOLD_WIN, 8, windows a peak marker holds before decay; at least 1.
REQ-006 Port: CLOCK  input  1  sole clock; all state on the rising edge.
REQ-007 Port: RESETN  input  1  asynchronous active-low reset.
REQ-008 Port: E  input  1  block enable.
REQ-009 Port: sample_tick  input  1  single-cycle strobe; mic_in is valid when high.
REQ-010 Port: mic_in  input  WIDTH  unsigned mic sample.
REQ-011 Port: mode  input  2  display mode: 0 raw, 1 bar, 2 bar+peak marker, 3 same as 1.
REQ-012 Port: led  output  NLED  registered LED drive.
REQ-013 Port: level  output  LVLW  registered current bar level, 0..NLED.

Function
REQ-014 Window: count sample_tick cycles 0..WINDOW-1 and track running max acc of mic_in over the window.
REQ-015 Closing tick (sample_tick with count = WINDOW-1): peak <= max(acc, mic_in), acc <= 0, count <= 0; otherwise a tick does acc <= max(acc, mic_in), count+1.
REQ-016 Level map: level <= 0 if peak = 0, else peak[WIDTH-1 -: log2(NLED)] + 1; 4095 -> 16, 1 -> 1, 256 -> 2.
REQ-017 level and led SHALL update on the same edge as peak; led shows the new window one cycle after the closing tick.
REQ-018 Mode 0: each sample_tick registers led <= mic_in zero-extended or truncated to NLED; window tracking continues.
REQ-019 Mode 1: led[i] = 1 for i < level, else 0 (thermometer from bit 0).
REQ-020 Mode 2: mode 1 bar OR'd with one marker bit led[hold-1] when hold > 0.
REQ-021 Hold FSM, states HOLD and DECAY, evaluated only at closing ticks: new level >= hold -> hold <= level, hcnt <= HOLD_WIN, state HOLD.
REQ-022 HOLD, new level < hold: hcnt decrements; on reaching 0 go to DECAY.
REQ-023 DECAY, new level < hold: hold decrements by 1 per window, floor 0; entering HOLD on the level >= hold condition per REQ-021.
REQ-024 Mode changes take effect at the next led update, without clearing tracking or hold state.
REQ-025 E low: led = 0, level = 0; count, acc, peak, hold, hcnt and FSM synchronously cleared to reset values; sample_tick ignored.
REQ-026 sample_tick while E is low is dropped; the first window starts at the first tick after E rises.

Reset
REQ-027 RESETN low SHALL immediately force led = 0, level = 0, count = 0, acc = 0, peak = 0, hold = 0, hcnt = 0, FSM = HOLD, regardless of CLOCK.
REQ-028 Reset asserted mid-window SHALL discard the partial window; after release, counting restarts at 0.
REQ-029 Reset release is synchronised internally; the first functional edge is the second rising CLOCK edge after RESETN rises.

Configuration
REQ-030 Macro MIC_LEVEL_METER_PEAK_HOLD_EN defined: hold register, hcnt and FSM present; mode 2 per REQ-020..023.
REQ-031 Macro undefined: hold logic not instantiated; mode 2 behaves exactly as mode 1; ports unchanged.

Verification (WIDTH=12, NLED=16, WINDOW=4, HOLD_WIN=2)
REQ-032 Reset, E=1, mode 1, four ticks with mic_in 100, 3000, 50, 7 -> one cycle after the 4th tick, level = 12 and led = 0x0FFF.
REQ-033 Mode 0, one tick with mic_in 0xABC -> next cycle led = 0x0ABC; E=0 for one cycle -> led = 0, level = 0.
REQ-034 Mode 2 with macro, window max 4095, then windows of 0 -> hold=16 for 2 further windows, then 15, 14, ... 0 per window; led = marker bit only.
REQ-035 Same stimulus without macro -> led identical to mode 1 (0xFFFF, then 0x0000).
REQ-036 RESETN low after 2 ticks of 4000, release, then 4 ticks of 16 -> level = 1 (partial window discarded).
REQ-037 E low during ticks, then E high and 4 ticks of 512 -> level = 3 exactly one cycle after the 4th enabled tick.
